// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-port memory. Latency: request in an IDLE cycle gives ack two cycles later.
// No backpressure. Each port holds its request until it sees its own ack. Three cycles per access.
module mem_arbiter #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [ADDR_SIZE-1:0] p0_addr,
    input  logic [WORD_SIZE-1:0] p0_wdata,
    output logic                 p0_ack,
    output logic [WORD_SIZE-1:0] p0_rdata,
    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [ADDR_SIZE-1:0] p1_addr,
    input  logic [WORD_SIZE-1:0] p1_wdata,
    output logic                 p1_ack,
    output logic [WORD_SIZE-1:0] p1_rdata,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_data_in,
    output logic                 mem_en_write,
    input  logic [WORD_SIZE-1:0] mem_data_out,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               state;
    logic                 ptr;
    logic                 owner;
    logic                 we_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 grant1;

    // A lone requester wins regardless of the pointer; on a tie the pointer decides.
    assign grant1 = p1_req && (!p0_req || ptr);

    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign busy        = (state != IDLE);
    // Reset during ACCESS must abandon the write, so the strobe is cut at once.
    assign mem_en_write = we_q && (state == ACCESS) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            owner    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    if (p0_req || p1_req) begin
                        owner   <= grant1;
                        ptr     <= !grant1;
                        we_q    <= grant1 ? p1_we    : p0_we;
                        addr_q  <= grant1 ? p1_addr  : p0_addr;
                        wdata_q <= grant1 ? p1_wdata : p0_wdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (owner) p1_rdata <= mem_data_out;
                        else       p0_rdata <= mem_data_out;
                    end
                    p0_ack <= !owner;
                    p1_ack <= owner;
                    state  <= RESP;
                end
                RESP: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory behind it.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       p0_req, p0_we, p1_req, p1_we;
    logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic       p0_ack, p1_ack, mem_en_write, busy;
    logic [7:0] p0_rdata, p1_rdata, mem_addr, mem_data_in, mem_data_out;
    logic [7:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en_write) mem[mem_addr] <= mem_data_in;
    assign mem_data_out = mem[mem_addr];

    mem_arbiter #(.WORD_SIZE(8), .ADDR_SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_en_write(mem_en_write),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, {28'd0, p0_ack, p1_ack, busy, mem_en_write}, 32'd0);
        check({tag, "_rdata"}, {16'd0, p0_rdata, p1_rdata}, 32'd0);
        check({tag, "_mem"}, {16'd0, mem_addr, mem_data_in}, 32'd0);
    endtask

    task automatic set_req(input int port, input logic v, input logic we,
                           input logic [7:0] a, input logic [7:0] d);
        if (port == 0) begin
            p0_req = v; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = v; p1_we = we; p1_addr = a; p1_wdata = d;
        end
    endtask

    // Raises one request from an IDLE cycle, returns ack latency (-1 on timeout) and read data.
    task automatic access(input int port, input logic we, input logic [7:0] a,
                          input logic [7:0] d, output logic [7:0] rd, output int lat);
        set_req(port, 1'b1, we, a, d);
        lat = -1;
        rd  = 8'h00;
        for (int c = 1; c <= 20; c++) begin
            tick;
            if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin
                lat = c;
                rd  = (port == 0) ? p0_rdata : p1_rdata;
                break;
            end
        end
        set_req(port, 1'b0, 1'b0, 8'h00, 8'h00);
        tick;
    endtask

    logic [7:0] rd;
    int         lat, a0, a1, n, g0, g1;
    int         order [8];
    logic       raise0, raise1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[1] = 8'h11;
        mem[2] = 8'h22;
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);

        // 1: reset and idle
        tick; check_idle("rst_c1");
        tick; check_idle("rst_c2");
        rst = 1'b0;
        tick; tick; check_idle("idle_after_rst");

        // 2: p0 write then read back
        set_req(0, 1'b1, 1'b1, 8'h10, 8'h3C);
        check("wr_c0_we", mem_en_write, 0);
        tick;
        check("wr_c1_we", mem_en_write, 1);
        check("wr_c1_busy", busy, 1);
        check("wr_c1_bus", {mem_addr, mem_data_in}, 16'h103C);
        check("wr_c1_ack", p0_ack, 0);
        tick;
        check("wr_c2_ack", p0_ack, 1);
        check("wr_c2_we", mem_en_write, 0);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        check("wr_c3_ack_busy", {p0_ack, busy}, 0);
        access(0, 1'b0, 8'h10, 8'h00, rd, lat);
        check("rd_lat", lat, 2);
        check("rd_data", rd, 8'h3C);

        // 3: simultaneous reads after reset
        rst = 1'b1; tick; rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
        a0 = -1; a1 = -1;
        for (int c = 1; c <= 8; c++) begin
            tick;
            check("t3_onehot", {31'd0, p0_ack & p1_ack}, 0);
            if (p0_ack) begin
                a0 = c; check("t3_p0_rdata", p0_rdata, 8'h11); p0_req = 1'b0;
            end
            if (p1_ack) begin
                a1 = c; check("t3_p1_rdata", p1_rdata, 8'h22); p1_req = 1'b0;
            end
        end
        check("t3_p0_ack_cycle", a0, 2);
        check("t3_p1_ack_cycle", a1, 5);

        // 4: round-robin with both ports saturating, then p1 alone
        rst = 1'b1; tick; rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
        n = 0; g0 = 0; g1 = 0; raise0 = 1'b0; raise1 = 1'b0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            tick;
            if (raise0) begin p0_req = 1'b1; raise0 = 1'b0; end
            if (raise1) begin p1_req = 1'b1; raise1 = 1'b0; end
            check("t4_onehot", {31'd0, p0_ack & p1_ack}, 0);
            if (p0_ack) begin
                order[n] = 0; n++; g0++; p0_req = 1'b0; raise0 = (g0 < 4);
            end else if (p1_ack) begin
                order[n] = 1; n++; g1++; p1_req = 1'b0; raise1 = (g1 < 4);
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        tick;
        check("t4_grants", n, 8);
        for (int i = 0; i < 8; i++) check($sformatf("t4_order%0d", i), order[i], i % 2);
        access(1, 1'b0, 8'h02, 8'h00, rd, lat);
        check("t4_p1_alone_lat", lat, 2);
        check("t4_p1_alone_data", rd, 8'h22);

        // 5: reset during a p1 write's ACCESS
        set_req(1, 1'b1, 1'b1, 8'h20, 8'hA5);
        tick;
        check("t5_access_we", mem_en_write, 1);
        rst = 1'b1;
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        check_idle("t5_after_rst");
        rst = 1'b0;
        tick;
        check("t5_no_ack", p1_ack, 0);
        access(1, 1'b0, 8'h20, 8'h00, rd, lat);
        check("t5_rd_lat", lat, 2);
        check("t5_rd_data", rd, 8'h00);

        // 6: write on p0, read same address on p1
        access(0, 1'b0, 8'h10, 8'h00, rd, lat);
        check("t6_p0_pre", rd, 8'h3C);
        access(0, 1'b1, 8'h30, 8'h77, rd, lat);
        check("t6_wr_lat", lat, 2);
        access(1, 1'b0, 8'h30, 8'h00, rd, lat);
        check("t6_p1_lat", lat, 2);
        check("t6_p1_rdata", rd, 8'h77);
        check("t6_p0_rdata_kept", p0_rdata, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
